// File: rtl/iq_magnitude_cordic_if.sv
// I/Q sample in, magnitude out: two valid/ready streams.
// master drives samples and out_ready; slave is the CORDIC engine.
interface iq_magnitude_cordic_if;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic               in_valid;
  logic               in_ready;
  logic [16:0]        mag_out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output i_in, q_in, in_valid, out_ready,
    input  in_ready, mag_out, out_valid
  );

  modport slave (
    input  i_in, q_in, in_valid, out_ready,
    output in_ready, mag_out, out_valid
  );
endinterface

// File: rtl/iq_magnitude_cordic.sv
// Iterative CORDIC vectoring: Q15 I/Q pair -> magnitude, one rotation per clock.
// Ports: clk, rst_n (async, active low), bus (slave: i/q in, mag out, handshakes).
module iq_magnitude_cordic #(
  parameter int ITER = 14,
  parameter int GW   = 2
) (
  input logic             clk,
  input logic             rst_n,
  iq_magnitude_cordic_if.slave bus
);

  localparam int W  = 19 + GW;
  localparam int PW = W + 16;
  localparam int KW = $clog2(ITER + 1);

  localparam logic signed [PW-1:0] KINV = PW'(19898);
  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (14 + GW);
  localparam logic signed [PW-1:0] MAXM = PW'(131071);

  typedef enum logic [2:0] {
    IDLE, PREP, ITERATE, SCALE, DONE
  } state_t;

  state_t               state_q, state_d;
  logic signed [15:0]   i_q, i_d;
  logic signed [15:0]   q_q, q_d;
  logic signed [W-1:0]  x_q, x_d;
  logic signed [W-1:0]  y_q, y_d;
  logic [KW-1:0]        k_q, k_d;
  logic [16:0]          mag_q, mag_d;
  logic                 ov_q, ov_d;

  logic signed [16:0]   i_ext, i_abs;
  logic signed [W-1:0]  x_sh, y_sh;
  logic signed [W-1:0]  x_upd, y_upd;
  logic signed [PW-1:0] p, rnd, sc;
  logic [16:0]          sat;

  // |-32768| needs the 17th bit
  assign i_ext = {i_q[15], i_q};
  assign i_abs = i_q[15] ? -i_ext : i_ext;

  assign x_sh = x_q >>> k_q;
  assign y_sh = y_q >>> k_q;

  // one adder pair; direction chosen by sign of y
  assign x_upd = y_q[W-1] ? x_q - y_sh : x_q + y_sh;
  assign y_upd = y_q[W-1] ? y_q + x_sh : y_q - x_sh;

  // undo CORDIC gain, drop guard/Q15 bits, round half up
  assign p   = PW'(x_q) * KINV;
  assign rnd = p + RND;
  assign sc  = rnd >>> (15 + GW);

  always_comb begin
    sat = '0;
    if (sc < 0)
      sat = '0;
    else if (sc > MAXM)
      sat = 17'h1ffff;
    else
      sat = sc[16:0];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    q_d     = q_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    mag_d   = mag_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          i_d     = bus.i_in;
          q_d     = bus.q_in;
          state_d = PREP;
        end
      end
      PREP: begin
        x_d     = W'(i_abs) <<< GW;
        y_d     = W'(q_q) <<< GW;
        k_d     = '0;
        state_d = ITERATE;
      end
      ITERATE: begin
        x_d = x_upd;
        y_d = y_upd;
        if (k_q == KW'(ITER - 1))
          state_d = SCALE;
        else
          k_d = k_q + 1'b1;
      end
      SCALE: begin
        mag_d   = sat;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      q_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      k_q     <= '0;
      mag_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      q_q     <= q_d;
      x_q     <= x_d;
      y_q     <= y_d;
      k_q     <= k_d;
      mag_q   <= mag_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.mag_out   = mag_q;
  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_iq_magnitude_cordic.sv
// Bench for iq_magnitude_cordic: scoreboard of reference magnitudes.
// Directed corners, backpressure, mid-run reset, random stalls.
module tb_iq_magnitude_cordic;

  localparam int ITER = 14;

  typedef struct {
    int mag;
    int tol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  iq_magnitude_cordic_if bus ();

  iq_magnitude_cordic #(
    .ITER(ITER),
    .GW  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_in = 0;
  int   n_out = 0;
  int   cyc = 0;
  int   acc_edge = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, int got, int exp, int tol = 0);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      errors++;
      $display("FAIL %s got %0d exp %0d tol %0d", tag, got, exp, tol);
    end
  endtask

  function automatic int refmag(int i, int q);
    real r;
    r = $sqrt(real'(i) * real'(i) + real'(q) * real'(q));
    return $rtoi(r + 0.5);
  endfunction

  // output side: choose out_ready, then score any handshake
  always @(negedge clk) begin
    exp_t e;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("mag", int'(bus.mag_out), e.mag, e.tol);
      end
    end
  end

  task automatic send(int i, int q, int tol = 2);
    int b;
    exp_t e;
    b = 0;
    @(negedge clk);
    while (!bus.in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!bus.in_ready) begin
      chk("in_tmo", 0, 1);
      return;
    end
    bus.i_in     = 16'(i);
    bus.q_in     = 16'(q);
    bus.in_valid = 1'b1;
    acc_edge     = cyc + 1;
    e.mag        = refmag(i, q);
    e.tol        = tol;
    sb.push_back(e);
    n_in++;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int b;
    b = 0;
    while (!bus.out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!bus.out_valid) chk("out_tmo", 0, 1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int i, q;
    bus.i_in     = '0;
    bus.q_in     = '0;
    bus.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ov", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.mag_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", int'(bus.in_ready), 1);

    // axes and 3-4-5 latency
    send(16384, 0);
    drain();
    send(0, -16384);
    drain();
    send(12000, -16000);
    wait_out();
    chk("latency", cyc - acc_edge, ITER + 2);
    drain();

    // extremes
    send(32767, 32767);
    send(-32768, -32768);
    send(0, 0, 0);
    send(-5, 0);
    drain();

    // backpressure with ignored input pulses
    rdy_mode = 2;
    send(3000, -4000);
    wait_out();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 5);
      bus.i_in     = 16'sd100;
      bus.q_in     = 16'sd100;
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_mag", int'(bus.mag_out), 5000, 2);
      chk("bp_rdy", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 0;
    drain();

    // reset while k == 5
    send(7000, 7000);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    n_in--;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_ov", int'(bus.out_valid), 0);
    chk("mr_mag", int'(bus.mag_out), 0);
    chk("mr_rdy", int'(bus.in_ready), 1);
    send(-20000, 15000);
    drain();

    // random with stalls
    rdy_mode = 1;
    for (int n = 0; n < 2000; n++) begin
      i = int'($urandom_range(0, 65535)) - 32768;
      q = int'($urandom_range(0, 65535)) - 32768;
      send(i, q);
    end
    drain();
    rdy_mode = 0;
    chk("count", n_out, n_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
